udc_bus_ctrl: RTL and testbench

UDC_BUS_CTRL -- requirements
Module: udc_bus_ctrl

---
 rtl/udc_bus_ctrl.sv | 149 ++++++++++++++
 tb/tb_udc_bus_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udc_bus_ctrl.sv
// Host-side bus controller for the UDC counter: sequences ncs/A/nwr/nrd
// with programmable setup/strobe/hold timing and issues start pulses.
module udc_bus_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       start_req,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       A0,
    output logic       A1,
    output logic       start_in,
    output logic [7:0] dout,
    output logic       dout_en,
    input  logic [7:0] din_i
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       rw_q, rw_n;
    logic [1:0] addr_q, addr_n;
    logic [7:0] data_q, data_n;
    logic       pend, pend_n, pend_set;
    logic       accept, busy, fire, strobe;
    logic       ncs_n, nwr_n, nrd_n, en_n;
    logic       ready_n, rsp_n;
    logic [1:0] a_n;
    logic [7:0] dout_n, rdata_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rw_n     = rw_q;
        addr_n   = addr_q;
        data_n   = data_q;
        accept   = cmd_valid & cmd_ready;
        rsp_n    = 1'b0;
        rdata_n  = rsp_rdata;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                    rw_n    = cmd_rw;
                    addr_n  = cmd_addr;
                    data_n  = cmd_wdata;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_n = STROBE;
                    cnt_n   = STROBE_LD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                    if (!rw_q) rdata_n = din_i;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_n = IDLE;
                    rsp_n   = ~rw_q;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so derive them from the next state.
        busy     = (state_n != IDLE);
        strobe   = (state_n == STROBE);
        pend_set = pend | start_req;
        fire     = ~busy & pend_set;
        pend_n   = pend_set & ~fire;
        ready_n  = ~busy & ~fire;
        ncs_n    = ~busy;
        nwr_n    = ~(strobe & rw_n);
        nrd_n    = ~(strobe & ~rw_n);
        en_n     = busy & rw_n;
        a_n      = busy ? addr_n : 2'b00;
        dout_n   = en_n ? data_n : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rw_q      <= 1'b0;
            addr_q    <= 2'b00;
            data_q    <= 8'h00;
            pend      <= 1'b0;
            cmd_ready <= 1'b0;
            start_in  <= 1'b0;
            ncs       <= 1'b1;
            nwr       <= 1'b1;
            nrd       <= 1'b1;
            A1        <= 1'b0;
            A0        <= 1'b0;
            dout      <= 8'h00;
            dout_en   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rw_q      <= rw_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            pend      <= pend_n;
            cmd_ready <= ready_n;
            start_in  <= fire;
            ncs       <= ncs_n;
            nwr       <= nwr_n;
            nrd       <= nrd_n;
            A1        <= a_n[1];
            A0        <= a_n[0];
            dout      <= dout_n;
            dout_en   <= en_n;
            rsp_valid <= rsp_n;
            rsp_rdata <= rdata_n;
        end
    end

endmodule

// File: tb/tb_udc_bus_ctrl.sv
// Bench for udc_bus_ctrl: directed timing checks plus random traffic
// compared every cycle against a transaction-phase model.
module tb_udc_bus_ctrl;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [1:0] cmd_addr = 2'b00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       start_req = 1'b0;
    logic       ncs, nwr, nrd, A0, A1, start_in;
    logic [7:0] dout;
    logic       dout_en;
    logic [7:0] din_i = 8'h00;

    logic       v1 = 1'b0;
    logic       ready1;
    logic       rw1 = 1'b0;
    logic [1:0] addr1 = 2'b00;
    logic [7:0] wdata1 = 8'h00;
    logic       rspv1;
    logic [7:0] rdata1;
    logic       sreq1 = 1'b0;
    logic       ncs1, nwr1, nrd1, a0_1, a1_1, start1;
    logic [7:0] dout1;
    logic       en1;
    logic [7:0] din1 = 8'h00;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    udc_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .start_req(start_req),
        .ncs(ncs), .nwr(nwr), .nrd(nrd),
        .A0(A0), .A1(A1), .start_in(start_in),
        .dout(dout), .dout_en(dout_en), .din_i(din_i)
    );

    udc_bus_ctrl #(
        .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(v1), .cmd_ready(ready1),
        .cmd_rw(rw1), .cmd_addr(addr1),
        .cmd_wdata(wdata1),
        .rsp_valid(rspv1), .rsp_rdata(rdata1),
        .start_req(sreq1),
        .ncs(ncs1), .nwr(nwr1), .nrd(nrd1),
        .A0(a0_1), .A1(a1_1), .start_in(start1),
        .dout(dout1), .dout_en(en1), .din_i(din1)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h",
                     nm, $time, act, exp);
        end
    endtask

    // Model: a transaction is "busy" for S+T+H cycles after accept;
    // m_k counts which of those cycles we are in (1-based).
    logic       m_busy = 1'b0;
    int         m_k = 0;
    logic       m_rw = 1'b0;
    logic [1:0] m_addr = 2'b00;
    logic [7:0] m_data = 8'h00;
    logic       m_pend = 1'b0;
    logic       m_start = 1'b0;
    logic       m_ready = 1'b0;
    logic       m_rsp = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_acc = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_k = 0; m_pend = 0;
            m_start = 0; m_ready = 0; m_rsp = 0;
            m_rdata = 8'h00; m_acc = 0;
        end else begin
            m_acc = 0;
            m_rsp = 0;
            if (m_busy) begin
                if (m_k == S + T && !m_rw) m_rdata = din_i;
                if (m_k == S + T + H) begin
                    m_busy = 0;
                    m_rsp = !m_rw;
                end else begin
                    m_k++;
                end
            end else if (m_ready && cmd_valid) begin
                m_busy = 1; m_k = 1; m_acc = 1;
                m_rw = cmd_rw;
                m_addr = cmd_addr;
                m_data = cmd_wdata;
            end
            m_pend = m_pend | start_req;
            m_start = !m_busy && m_pend;
            if (m_start) m_pend = 0;
            m_ready = !m_busy && !m_start;
        end
    end

    always @(negedge clk) begin : cmp
        logic stb;
        stb = m_busy && m_k > S && m_k <= S + T;
        chk("ncs", ncs, !m_busy);
        chk("nwr", nwr, !(stb && m_rw));
        chk("nrd", nrd, !(stb && !m_rw));
        chk("dout_en", dout_en, m_busy && m_rw);
        chk("cmd_ready", cmd_ready, m_ready);
        chk("start_in", start_in, m_start);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("strobe_excl", nwr | nrd, 1);
        chk("start_vs_ncs", start_in & ~ncs, 0);
        if (m_busy) chk("addr", {A1, A0}, m_addr);
        if (m_busy && m_rw) chk("dout", dout, m_data);
        if (!reset) begin
            chk("rst_addr", {A1, A0}, 0);
            chk("rst_dout", dout, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_ncs", ncs, 1);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst1_ncs", ncs1, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);

        // single write, addr 1, data 5A
        cmd_valid = 1; cmd_rw = 1; cmd_addr = 2'd1;
        cmd_wdata = 8'h5A;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 0;
            if (n <= 4) begin
                chk("w_ncs", ncs, 0);
                chk("w_addr", {A1, A0}, 2'b01);
                chk("w_dout", dout, 8'h5A);
                chk("w_en", dout_en, 1);
                chk("w_nwr", nwr, (n == 2 || n == 3) ? 0 : 1);
            end else begin
                chk("w_end_ncs", ncs, 1);
                chk("w_end_ready", cmd_ready, 1);
                chk("w_no_rsp", rsp_valid, 0);
            end
        end

        // single read, addr 2, din 3C
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 2'd2;
        din_i = 8'h3C;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 0;
            chk("r_en", dout_en, 0);
            if (n <= 4)
                chk("r_nrd", nrd, (n == 2 || n == 3) ? 0 : 1);
            chk("r_rspv", rsp_valid, n == 5);
            if (n == 5) chk("r_data", rsp_rdata, 8'h3C);
        end

        // back-to-back writes with cmd_valid held
        cmd_valid = 1; cmd_rw = 1; cmd_addr = 2'd3;
        cmd_wdata = 8'h11;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) cmd_wdata = 8'h22;
            if (n <= 4) chk("b2b_ready", cmd_ready, 0);
            if (n == 5) begin
                chk("b2b_gap_ncs", ncs, 1);
                chk("b2b_gap_ready", cmd_ready, 1);
            end
            if (n == 6) begin
                chk("b2b_2nd_ncs", ncs, 0);
                chk("b2b_2nd_dout", dout, 8'h22);
                cmd_valid = 0;
            end
        end
        repeat (4) @(negedge clk);

        // start_req during write strobe, then a pending read
        cmd_valid = 1; cmd_rw = 1; cmd_addr = 2'd0;
        cmd_wdata = 8'h77;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 0;
            if (n == 2) start_req = 1;
            if (n == 3) begin
                start_req = 0;
                cmd_valid = 1; cmd_rw = 0; cmd_addr = 2'd1;
            end
            if (n <= 4) chk("s_none", start_in, 0);
            if (n == 5) begin
                chk("s_pulse", start_in, 1);
                chk("s_ready", cmd_ready, 0);
                chk("s_ncs", ncs, 1);
            end
            if (n == 6) begin
                chk("s_drop", start_in, 0);
                chk("s_ready2", cmd_ready, 1);
            end
            if (n == 7) begin
                chk("s_acc", ncs, 0);
                cmd_valid = 0;
            end
        end
        repeat (4) @(negedge clk);

        // reset during read strobe
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 2'd2;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        chk("ar_nrd_pre", nrd, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_nrd", nrd, 1);
        chk("ar_ncs", ncs, 1);
        chk("ar_en", dout_en, 0);
        chk("ar_ready", cmd_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ar_rel_ready", cmd_ready, 1);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("ar_no_rsp", rsp_valid, 0);
            chk("ar_no_nrd", nrd, 1);
        end

        // minimal timing instance: 4-cycle read
        v1 = 1; rw1 = 0; addr1 = 2'd3; din1 = 8'hA5;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) v1 = 0;
            if (n <= 3) chk("m_nrd", nrd1, n == 2 ? 0 : 1);
            chk("m_ncs", ncs1, n >= 4);
            chk("m_rspv", rspv1, n == 4);
            if (n == 4) begin
                chk("m_ready", ready1, 1);
                chk("m_data", rdata1, 8'hA5);
            end
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (m_acc) cmd_valid = 0;
            if (!cmd_valid && $urandom_range(0, 2) == 0) begin
                cmd_valid = 1;
                cmd_rw = 1'($urandom_range(0, 1));
                cmd_addr = 2'($urandom);
                cmd_wdata = 8'($urandom);
            end
            start_req = ($urandom_range(0, 9) == 0);
            din_i = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
        cmd_valid = 0;
        start_req = 0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
